reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks outstanding writes to each architectural register of the 8 x 16-bit register file.
- Decides each cycle whether the instruction at issue may read its sources and claim its destination; stalls it on a read-after-write hazard or a saturated pending counter.
- Sits between decode/issue and the register file read ports; writeback reports completions.
- Exploits the register file timing (write at posedge, read at negedge): a register retired this cycle is readable this cycle.

Parameters:
NUM_REGS, 8, number of tracked registers
ADDR_W, 3, register address width (log2 NUM_REGS)
CNT_W, 2, width of per-register pending counter; max outstanding writes = 2^CNT_W - 1

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all pending state (pipeline squash)
issue_valid  in  1  instruction present at issue
issue_src1  in  ADDR_W  source 1 register address
issue_src1_used  in  1  source 1 is read
issue_src2  in  ADDR_W  source 2 register address
issue_src2_used  in  1  source 2 is read
issue_wr_en  in  1  instruction writes a register
issue_dst  in  ADDR_W  destination register address
wb_valid  in  1  a write to the register file completes this cycle
wb_dst  in  ADDR_W  register written by that write
issue_stall  out  1  combinational; 1 = instruction must hold
issue_fire  out  1  combinational; issue_valid & ~issue_stall & ~flush
pending  out  NUM_REGS  registered; bit r = counter r nonzero
wb_err  out  1  registered, sticky; writeback to a register with zero pending

Behaviour:
- State: cnt[r] (CNT_W bits) per register, plus wb_err.
- Reset (rst=1, asynchronous): all cnt=0, pending=0, wb_err=0. Effect is immediate, also mid-operation. issue_stall follows the cleared state combinationally.
- wb_hit(r) = wb_valid & (wb_dst==r) & (cnt[r]!=0).
- Source hazard, per used source s: cnt[s]!=0 AND NOT (wb_hit(s) & cnt[s]==1).
  - A last outstanding write retiring this cycle is not a hazard, because of the half-cycle register file timing.
  - Unused sources are ignored.
- Destination hazard: issue_wr_en & cnt[dst]==max AND NOT wb_hit(dst). Write-after-write is otherwise permitted up to max outstanding.
- issue_stall = issue_valid & (src1 hazard | src2 hazard | dst hazard). It is 0 when issue_valid=0.
- Counter update at posedge, per register r:
  - inc = issue_fire & issue_wr_en & issue_dst==r
  - dec = wb_hit(r)
  - inc&dec: unchanged; inc only: +1; dec only: -1.
- Counters never wrap. Saturation is prevented by the destination hazard; underflow is prevented by the wb_hit gating.
- wb_valid to a register with cnt==0: no counter change, wb_err set to 1 at the next edge. wb_err is cleared only by rst, not by flush.
- flush=1: issue_fire forced 0. At the edge all cnt←0, overriding any same-cycle inc or dec.
- Latency:
  - Stall decision is 0-cycle (combinational from inputs and current state).
  - pending reflects updates one cycle after the triggering edge inputs.
- Instruction with src==dst (e.g. R3←R3+R1): judged on source hazard only against existing writes; its own claim takes effect at the edge.
- Issue and wb on different registers in the same cycle are independent.

Test Plan:
1. Reset, then issue dst=R2 (fire). Next cycle issue src1=R2 with no wb -> issue_stall=1, pending=8'b0000_0100. Then wb_dst=R2 in the same cycle as the waiting issue -> stall=0, fire=1, pending=0 after the edge.
2. Issue dst=R5 three times with no wb -> cnt[5]=3. Fourth issue dst=R5 -> stall=1. Same issue with wb_dst=R5 in the same cycle -> fire=1, cnt[5] stays 3.
3. cnt[1]=2, wb_dst=R1, issue src2=R1 in the same cycle -> stall=1 (count not last). Next cycle wb_dst=R1 again -> stall=0.
4. wb_valid with wb_dst=R7 while cnt[7]=0 -> wb_err=1 next cycle, all counters unchanged. flush does not clear it; rst pulse clears it.
5. Pending on R0, R3, R4 with flush=1 and issue_valid dst=R6 -> issue_fire=0, pending=0 after the edge.
6. Assert rst asynchronously mid-cycle with pending=8'hFF -> pending=0 and wb_err=0 before the next clk edge.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between decode, the register scoreboard and writeback.
// Master drives the instruction at issue and completions; slave returns stall/status.
interface reg_scoreboard_if #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = 3
);
   logic              flush;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_src1;
   logic              issue_src1_used;
   logic [ADDR_W-1:0] issue_src2;
   logic              issue_src2_used;
   logic              issue_wr_en;
   logic [ADDR_W-1:0] issue_dst;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_dst;
   logic              issue_stall;
   logic              issue_fire;
   logic [NUM_REGS-1:0] pending;
   logic              wb_err;

   modport master (
      output flush, issue_valid, issue_src1, issue_src1_used, issue_src2,
             issue_src2_used, issue_wr_en, issue_dst, wb_valid, wb_dst,
      input  issue_stall, issue_fire, pending, wb_err
   );

   modport slave (
      input  flush, issue_valid, issue_src1, issue_src1_used, issue_src2,
             issue_src2_used, issue_wr_en, issue_dst, wb_valid, wb_dst,
      output issue_stall, issue_fire, pending, wb_err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters deciding issue stalls (RAW / counter
// saturation); a retiring last write is readable the same cycle.
module reg_scoreboard #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned CNT_W    = 2
) (
   input logic            clk,
   input logic            rst,
   reg_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_REGS-1:0]            pending_q, pending_d;
   logic                           wb_err_q, wb_err_d;

   logic [NUM_REGS-1:0] wb_hit;
   logic                src1_haz, src2_haz, dst_haz;
   logic                stall, fire;

   always_comb begin
      wb_hit = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         wb_hit[r] = sb.wb_valid && (sb.wb_dst == ADDR_W'(r)) && (cnt_q[r] != '0);
      end
   end

   // Register file writes at posedge and reads at negedge, so the final
   // outstanding write retiring now does not block a reader.
   always_comb begin
      src1_haz = sb.issue_src1_used && (cnt_q[sb.issue_src1] != '0) &&
                 !(wb_hit[sb.issue_src1] && (cnt_q[sb.issue_src1] == CNT_ONE));
      src2_haz = sb.issue_src2_used && (cnt_q[sb.issue_src2] != '0) &&
                 !(wb_hit[sb.issue_src2] && (cnt_q[sb.issue_src2] == CNT_ONE));
      dst_haz  = sb.issue_wr_en && (cnt_q[sb.issue_dst] == CNT_MAX) && !wb_hit[sb.issue_dst];
      stall    = sb.issue_valid && (src1_haz || src2_haz || dst_haz);
      fire     = sb.issue_valid && !stall && !sb.flush;
   end

   always_comb begin
      cnt_d     = cnt_q;
      pending_d = '0;
      wb_err_d  = wb_err_q || (sb.wb_valid && (cnt_q[sb.wb_dst] == '0));
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         logic inc;
         inc = fire && sb.issue_wr_en && (sb.issue_dst == ADDR_W'(r));
         if (inc && !wb_hit[r]) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (!inc && wb_hit[r]) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end
      end
      if (sb.flush) begin
         cnt_d = '0;
      end
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         pending_d[r] = (cnt_d[r] != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         pending_q <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         wb_err_q  <= wb_err_d;
      end
   end

   assign sb.issue_stall = stall;
   assign sb.issue_fire  = fire;
   assign sb.pending     = pending_q;
   assign sb.wb_err      = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios then random traffic, all checked
// against a counting model of outstanding writes per register.
module tb_reg_scoreboard;
   localparam int NR  = 8;
   localparam int MAX = 3;

   logic clk;
   logic rst;

   reg_scoreboard_if #(.NUM_REGS(8), .ADDR_W(3)) sb_if ();

   reg_scoreboard #(.NUM_REGS(8), .ADDR_W(3), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state and current stimulus
   int m_cnt [NR];
   bit m_err;
   bit i_v, i_s1u, i_s2u, i_we, i_wbv, i_fl;
   int i_s1, i_s2, i_dst, i_wbd;
   logic last_stall, last_fire;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input int s1, input bit s1u, input int s2, input bit s2u,
                        input bit we, input int dst, input bit wbv, input int wbd, input bit fl);
      i_v = v; i_s1 = s1; i_s1u = s1u; i_s2 = s2; i_s2u = s2u;
      i_we = we; i_dst = dst; i_wbv = wbv; i_wbd = wbd; i_fl = fl;
      sb_if.issue_valid     = v;
      sb_if.issue_src1      = 3'(s1);
      sb_if.issue_src1_used = s1u;
      sb_if.issue_src2      = 3'(s2);
      sb_if.issue_src2_used = s2u;
      sb_if.issue_wr_en     = we;
      sb_if.issue_dst       = 3'(dst);
      sb_if.wb_valid        = wbv;
      sb_if.wb_dst          = 3'(wbd);
      sb_if.flush           = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic int retiring(int r);
      return (i_wbv && i_wbd == r && m_cnt[r] > 0) ? 1 : 0;
   endfunction

   function automatic logic [7:0] m_pending();
      logic [7:0] p;
      for (int r = 0; r < NR; r++) p[r] = (m_cnt[r] > 0);
      return p;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      m_err = 0;
   endtask

   // One clock: check combinational and registered outputs at negedge, then advance model.
   task automatic run_cycle();
      bit e_stall, e_fire;
      int nxt [NR];
      @(negedge clk);
      e_stall = i_v && ((i_s1u && (m_cnt[i_s1] - retiring(i_s1)) > 0) ||
                        (i_s2u && (m_cnt[i_s2] - retiring(i_s2)) > 0) ||
                        (i_we  && (m_cnt[i_dst] - retiring(i_dst)) >= MAX));
      e_fire  = i_v && !e_stall && !i_fl;
      last_stall = sb_if.issue_stall;
      last_fire  = sb_if.issue_fire;
      chk("stall",   32'(sb_if.issue_stall), 32'(e_stall));
      chk("fire",    32'(sb_if.issue_fire),  32'(e_fire));
      chk("pending", 32'(sb_if.pending),     32'(m_pending()));
      chk("wb_err",  32'(sb_if.wb_err),      32'(m_err));
      for (int r = 0; r < NR; r++) begin
         nxt[r] = i_fl ? 0 : m_cnt[r] + ((e_fire && i_we && i_dst == r) ? 1 : 0) - retiring(r);
      end
      if (i_wbv && m_cnt[i_wbd] == 0) m_err = 1;
      @(posedge clk);
      for (int r = 0; r < NR; r++) m_cnt[r] = nxt[r];
      #1;
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_pending", 32'(sb_if.pending), 32'h0);
      chk("rst_wb_err",  32'(sb_if.wb_err),  32'h0);
      chk("rst_stall",   32'(sb_if.issue_stall), 32'h0);

      // 1: RAW on R2, released by same-cycle retire
      drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); run_cycle();
      chk("t1_pend", 32'(sb_if.pending), 32'h04);
      drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); run_cycle();
      chk("t1_stall", 32'(last_stall), 32'h1);
      chk("t1_pend2", 32'(sb_if.pending), 32'h04);
      drive(1, 2, 1, 0, 0, 0, 0, 1, 2, 0); run_cycle();
      chk("t1_stall_wb", 32'(last_stall), 32'h0);
      chk("t1_fire_wb",  32'(last_fire),  32'h1);
      chk("t1_pend3", 32'(sb_if.pending), 32'h00);

      // 2: saturate R5, retire-while-claim keeps count
      repeat (3) begin drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); run_cycle(); end
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); run_cycle();
      chk("t2_sat_stall", 32'(last_stall), 32'h1);
      drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0); run_cycle();
      chk("t2_fire", 32'(last_fire), 32'h1);
      repeat (2) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); run_cycle(); end
      chk("t2_pend_after2", 32'(sb_if.pending), 32'h20);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); run_cycle();
      chk("t2_pend_after3", 32'(sb_if.pending), 32'h00);

      // 3: non-last retire does not release a reader
      repeat (2) begin drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); run_cycle(); end
      drive(1, 0, 0, 1, 1, 0, 0, 1, 1, 0); run_cycle();
      chk("t3_stall", 32'(last_stall), 32'h1);
      drive(1, 0, 0, 1, 1, 0, 0, 1, 1, 0); run_cycle();
      chk("t3_release", 32'(last_stall), 32'h0);

      // 4: stray writeback sets sticky wb_err
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); run_cycle();
      chk("t4_err", 32'(sb_if.wb_err), 32'h1);
      chk("t4_pend", 32'(sb_if.pending), 32'h00);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
      chk("t4_err_flush", 32'(sb_if.wb_err), 32'h1);
      idle();
      rst = 1'b1; #2 rst = 1'b0; model_reset();
      chk("t4_err_rst", 32'(sb_if.wb_err), 32'h0);

      // 5: flush squashes issue and clears pending
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); run_cycle();
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); run_cycle();
      drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); run_cycle();
      chk("t5_pend", 32'(sb_if.pending), 32'h19);
      drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 1); run_cycle();
      chk("t5_fire", 32'(last_fire), 32'h0);
      chk("t5_pend_clr", 32'(sb_if.pending), 32'h00);

      // 6: async reset mid-cycle with everything pending
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); run_cycle();
      for (int r = 1; r < NR; r++) begin drive(1, 0, 0, 0, 0, 1, r, 0, 0, 0); run_cycle(); end
      chk("t6_pend_ff", 32'(sb_if.pending), 32'hFF);
      chk("t6_err_set", 32'(sb_if.wb_err), 32'h1);
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b1;
      #1;
      chk("t6_pend_async", 32'(sb_if.pending), 32'h00);
      chk("t6_err_async",  32'(sb_if.wb_err),  32'h0);
      chk("t6_stall_async", 32'(sb_if.issue_stall), 32'h0);
      #1 rst = 1'b0;
      model_reset();

      // random traffic, writebacks biased toward pending registers
      for (int n = 0; n < 600; n++) begin
         int wbd;
         wbd = $urandom_range(NR - 1);
         if ($urandom_range(3) != 0) begin
            for (int k = 0; k < NR; k++) if (m_cnt[(wbd + k) % NR] > 0) begin wbd = (wbd + k) % NR; break; end
         end
         drive($urandom_range(3) != 0, $urandom_range(NR - 1), $urandom_range(1) == 1,
               $urandom_range(NR - 1), $urandom_range(1) == 1, $urandom_range(3) != 0,
               $urandom_range(3), $urandom_range(2) == 0, wbd, $urandom_range(31) == 0);
         run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
